// File: rtl/tone_meter.sv
// tone_meter: measures an asynchronous square-wave tone.
// sig_in is synchronized and debounced; the period and high time between
// consecutive filtered rising edges are averaged over 4 samples.
//
// Ports:
//   clk        system clock, all flops on rising edge
//   rst        asynchronous active-high reset
//   enable     measurement enable; low forces IDLE
//   sig_in     asynchronous tone input
//   period     averaged period in clk cycles
//   high_time  averaged high time in clk cycles
//   valid      one-cycle pulse when period/high_time update
//   silent     high while no tone is detected
module tone_meter #(
    parameter int          FILT_LEN = 4,
    parameter logic [31:0] TIMEOUT  = 32'd2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sig_in,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic        valid,
    output logic        silent
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, SILENT} state_t;

    // ---------------- synchronizer + stability filter ----------------
    logic          s1_q, s2_q;
    logic          filt_q, filt_d;
    logic          fprev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          rise;

    // fcnt counts consecutive samples that disagree with the filtered level;
    // the level flips on the FILT_LEN-th disagreeing sample.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (s2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            filt_q  <= 1'b0;
            fprev_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            filt_q  <= filt_d;
            fprev_q <= filt_q;
            fcnt_q  <= fcnt_d;
        end
    end

    assign rise = filt_q & ~fprev_q;

    // ---------------- measurement FSM ----------------
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hcnt_q, hcnt_d;
    logic [33:0] pacc_q, pacc_d;
    logic [33:0] hacc_q, hacc_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic        valid_q, valid_d;
    logic        silent_q, silent_d;

    logic [31:0] cnt_inc;
    logic        timeout_hit;
    logic [33:0] p_sum, h_sum;

    // cnt saturates at TIMEOUT so a stalled tone can never wrap it
    assign cnt_inc     = (cnt_q >= TIMEOUT) ? TIMEOUT : cnt_q + 32'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT);
    assign p_sum       = pacc_q + {2'b00, cnt_q};
    assign h_sum       = hacc_q + {2'b00, hcnt_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        pacc_d   = pacc_q;
        hacc_d   = hacc_q;
        idx_d    = idx_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        silent_d = silent_q;

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            pacc_d   = '0;
            hacc_d   = '0;
            idx_d    = '0;
            silent_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                // ARM and SILENT: a rise only starts a measurement window.
                // The rise cycle itself counts as cycle 1 (and is high).
                ARM, SILENT: begin
                    if (rise) begin
                        state_d = MEAS;
                        cnt_d   = 32'd1;
                        hcnt_d  = 32'd1;
                        pacc_d  = '0;
                        hacc_d  = '0;
                        idx_d   = '0;
                    end else if (state_q == ARM) begin
                        cnt_d = cnt_inc;
                        if (timeout_hit) begin
                            state_d  = SILENT;
                            silent_d = 1'b1;
                            pacc_d   = '0;
                            hacc_d   = '0;
                            idx_d    = '0;
                        end
                    end
                end
                MEAS: begin
                    // rise takes priority over a simultaneous timeout
                    if (rise) begin
                        cnt_d  = 32'd1;
                        hcnt_d = 32'd1;
                        if (idx_q == 2'd3) begin
                            period_d = p_sum[33:2];
                            high_d   = h_sum[33:2];
                            valid_d  = 1'b1;
                            silent_d = 1'b0;
                            pacc_d   = '0;
                            hacc_d   = '0;
                            idx_d    = '0;
                        end else begin
                            pacc_d = p_sum;
                            hacc_d = h_sum;
                            idx_d  = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d  = cnt_inc;
                        hcnt_d = hcnt_q + {31'd0, filt_q};
                        if (timeout_hit) begin
                            state_d  = SILENT;
                            silent_d = 1'b1;
                            pacc_d   = '0;
                            hacc_d   = '0;
                            idx_d    = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            pacc_q   <= '0;
            hacc_q   <= '0;
            idx_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            silent_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            pacc_q   <= pacc_d;
            hacc_q   <= hacc_d;
            idx_q    <= idx_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            silent_q <= silent_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign silent    = silent_q;

endmodule
